// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and load/store.
// Optional WAIT-state timeout with sticky arb_err: define MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  if_req,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   output logic                  if_ack,
   output logic [DATA_WIDTH-1:0] if_rdata,
   input  logic                  dm_req,
   input  logic                  dm_we,
   input  logic [ADDR_WIDTH-1:0] dm_addr,
   input  logic [DATA_WIDTH-1:0] dm_wdata,
   output logic                  dm_ack,
   output logic [DATA_WIDTH-1:0] dm_rdata,
   output logic                  mem_req_valid,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_ack,
   output logic                  arb_err
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   state_t                state, state_nxt;
   logic                  owner_dm;
   logic                  last_dm;
   logic                  we_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [DATA_WIDTH-1:0] if_rdata_q, dm_rdata_q;
   logic                  grant, grant_dm;
   logic                  timeout;

   // Data port wins when alone, or on contention when fetch had the last grant.
   assign grant    = if_req | dm_req;
   assign grant_dm = dm_req & (~if_req | ~last_dm);

`ifdef MEM_ARB_TIMEOUT_EN
   logic [7:0] to_cnt;
   logic       err_q;

   assign timeout = (state == S_WAIT) && !mem_ack && (to_cnt == 8'(TIMEOUT_CYCLES - 1));
   assign arb_err = err_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         to_cnt <= '0;
         err_q  <= 1'b0;
      end else begin
         if (state == S_ISSUE)
            to_cnt <= '0;
         else if (state == S_WAIT)
            to_cnt <= to_cnt + 8'd1;
         if (timeout)
            err_q <= 1'b1;
      end
   end
`else
   assign timeout = 1'b0;
   assign arb_err = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (grant) state_nxt = S_ISSUE;
         S_ISSUE: state_nxt = S_WAIT;
         S_WAIT:  if (mem_ack || timeout) state_nxt = S_RESP;
         S_RESP:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         owner_dm   <= 1'b0;
         last_dm    <= 1'b1;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            S_IDLE: begin
               if (grant) begin
                  owner_dm <= grant_dm;
                  last_dm  <= grant_dm;
                  we_q     <= grant_dm & dm_we;
                  addr_q   <= grant_dm ? dm_addr  : if_addr;
                  wdata_q  <= grant_dm ? dm_wdata : '0;
               end
            end
            S_WAIT: begin
               if (mem_ack) begin
                  if (!we_q) begin
                     if (owner_dm) dm_rdata_q <= mem_rdata;
                     else          if_rdata_q <= mem_rdata;
                  end
               end else if (timeout) begin
                  // Poisoned data tells the requester the memory never answered.
                  if (owner_dm) dm_rdata_q <= DATA_WIDTH'(32'hDEAD_BEEF);
                  else          if_rdata_q <= DATA_WIDTH'(32'hDEAD_BEEF);
               end
            end
            default: ;
         endcase
      end
   end

   assign mem_req_valid = (state == S_ISSUE);
   assign mem_we        = we_q;
   assign mem_addr      = addr_q;
   assign mem_wdata     = wdata_q;
   assign if_ack        = (state == S_RESP) && !owner_dm;
   assign dm_ack        = (state == S_RESP) &&  owner_dm;
   assign if_rdata      = if_rdata_q;
   assign dm_rdata      = dm_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small latency-programmable memory model.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req, dm_req, dm_we;
   logic [31:0] if_addr, dm_addr, dm_wdata;
   logic        if_ack, dm_ack;
   logic [31:0] if_rdata, dm_rdata;
   logic        mem_req_valid, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_ack;
   logic        arb_err;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_ack(dm_ack), .dm_rdata(dm_rdata),
      .mem_req_valid(mem_req_valid), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .arb_err(arb_err)
   );

   // Memory model: ack_dly = 0 acks in the cycle after mem_req_valid, < 0 never acks.
   int          ack_dly = 0;
   logic [31:0] mem [16];
   logic        pend;
   int          cnt;
   logic [3:0]  p_addr;
   logic        last_we;
   logic [31:0] last_addr, last_wdata;
   int          nreq = 0, if_ack_cnt = 0, dm_ack_cnt = 0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_ack   <= 1'b0;
         mem_rdata <= '0;
         pend      <= 1'b0;
         cnt       <= 0;
         p_addr    <= '0;
         mem[0]    <= 32'h00a00313;
         mem[3]    <= 32'hCAFE0003;
         mem[5]    <= 32'hBAD00005;
      end else begin
         mem_ack <= 1'b0;
         if (mem_req_valid) begin
            if (mem_we) mem[mem_addr[3:0]] <= mem_wdata;
            if (ack_dly == 0) begin
               mem_ack   <= 1'b1;
               mem_rdata <= mem[mem_addr[3:0]];
            end else if (ack_dly > 0) begin
               pend   <= 1'b1;
               cnt    <= ack_dly - 1;
               p_addr <= mem_addr[3:0];
            end
         end else if (pend) begin
            if (cnt == 0) begin
               mem_ack   <= 1'b1;
               mem_rdata <= mem[p_addr];
               pend      <= 1'b0;
            end else begin
               cnt <= cnt - 1;
            end
         end
      end
   end

   always @(posedge clk) begin
      if (mem_req_valid) begin
         nreq       <= nreq + 1;
         last_we    <= mem_we;
         last_addr  <= mem_addr;
         last_wdata <= mem_wdata;
      end
      if (if_ack) if_ack_cnt <= if_ack_cnt + 1;
      if (dm_ack) dm_ack_cnt <= dm_ack_cnt + 1;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      if_req = 0; dm_req = 0; dm_we = 0;
      if_addr = '0; dm_addr = '0; dm_wdata = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   // One uncontended transaction; cyc is the negedge count at which ack was seen, -1 if none.
   task automatic txn(input bit dm, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                      output int cyc, output logic [31:0] rd);
      @(negedge clk);
      if (dm) begin
         dm_req = 1; dm_we = we; dm_addr = addr; dm_wdata = wdata;
      end else begin
         if_req = 1; if_addr = addr;
      end
      cyc = -1;
      rd  = '0;
      for (int n = 1; n <= 60; n++) begin
         @(negedge clk);
         if (dm ? dm_ack : if_ack) begin
            cyc = n;
            rd  = dm ? dm_rdata : if_rdata;
            break;
         end
      end
      if (dm) dm_req = 0; else if_req = 0;
   endtask

   task automatic contend(output int t_if, output int t_dm);
      @(negedge clk);
      if_req = 1; if_addr = 32'd0;
      dm_req = 1; dm_we = 0; dm_addr = 32'd3;
      t_if = -1; t_dm = -1;
      for (int n = 1; n <= 60; n++) begin
         @(negedge clk);
         if (if_ack && t_if < 0) begin t_if = n; if_req = 0; end
         if (dm_ack && t_dm < 0) begin t_dm = n; dm_req = 0; end
         if (t_if >= 0 && t_dm >= 0) break;
      end
      if_req = 0; dm_req = 0;
   endtask

   initial begin
      int          cyc, t_if, t_dm, n0, a0;
      logic [31:0] rd;
      logic        addr_ok, acked;

      reset = 1'b1;
      if_req = 0; dm_req = 0; dm_we = 0;
      if_addr = '0; dm_addr = '0; dm_wdata = '0;
      repeat (2) @(negedge clk);
      check("rst_acks", {if_ack, dm_ack, mem_req_valid, mem_we, arb_err}, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_rdata", {if_rdata, dm_rdata}, 0);
      reset = 1'b0;

      // Fetch: ack three cycles after the request is sampled, one memory request.
      n0 = nreq; a0 = if_ack_cnt;
      txn(0, 0, 32'd0, 32'd0, cyc, rd);
      repeat (3) @(negedge clk);
      check("fetch_rdata", rd, 32'h00a00313);
      check("fetch_latency", cyc, 3);
      check("fetch_nreq", nreq - n0, 1);
      check("fetch_nack", if_ack_cnt - a0, 1);

      // Data write then read back.
      txn(1, 1, 32'd7, 32'h1234_5678, cyc, rd);
      check("wr_ack", cyc, 3);
      check("wr_mem_we", last_we, 1);
      check("wr_mem_addr", last_addr, 7);
      check("wr_mem_wdata", last_wdata, 32'h1234_5678);
      check("wr_rdata_kept", dm_rdata, 0);
      txn(1, 0, 32'd7, 32'd0, cyc, rd);
      check("rd_rdata", rd, 32'h1234_5678);
      check("rd_mem_we", last_we, 0);

      // Contention right after reset: fetch first, data four cycles later.
      do_reset();
      contend(t_if, t_dm);
      check("cont1_if_t", t_if, 3);
      check("cont1_dm_t", t_dm, 7);
      check("cont1_gap", (t_dm - t_if) >= 4, 1);
      check("cont1_dm_rdata", dm_rdata, 32'hCAFE0003);
      contend(t_if, t_dm);
      check("cont2_if_first", (t_if >= 0) && (t_if < t_dm), 1);
      txn(0, 0, 32'd0, 32'd0, cyc, rd);
      contend(t_if, t_dm);
      check("cont3_dm_first", (t_dm >= 0) && (t_dm < t_if), 1);

      // Address change after grant is ignored.
      ack_dly = 5;
      @(negedge clk);
      dm_req = 1; dm_we = 0; dm_addr = 32'd3;
      addr_ok = 1; acked = 0;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (n == 3) dm_addr = 32'd5;
         if (mem_addr !== 32'd3) addr_ok = 0;
         if (dm_ack) begin acked = 1; break; end
      end
      check("chg_acked", acked, 1);
      check("chg_addr_held", addr_ok, 1);
      check("chg_rdata", dm_rdata, 32'hCAFE0003);
      dm_req = 0;
      ack_dly = 0;

      // Reset while waiting for memory.
      ack_dly = -1;
      a0 = if_ack_cnt;
      @(negedge clk);
      if_req = 1; if_addr = 32'd4;
      repeat (4) @(negedge clk);
      check("mid_mem_addr", mem_addr, 4);
      reset = 1'b1;
      #1;
      check("mid_no_ack", if_ack_cnt - a0, 0);
      check("mid_outs", {if_ack, dm_ack, mem_req_valid, mem_we, arb_err}, 0);
      check("mid_addr_rdata", {mem_addr, if_rdata, dm_rdata}, 0);
      if_req = 0;
      @(negedge clk);
      reset = 1'b0;
      ack_dly = 0;
      txn(0, 0, 32'd0, 32'd0, cyc, rd);
      check("post_rdata", rd, 32'h00a00313);
      check("post_latency", cyc, 3);

      // Memory never answers.
      ack_dly = -1;
      txn(1, 0, 32'd3, 32'd0, cyc, rd);
`ifdef MEM_ARB_TIMEOUT_EN
      check("to_latency", cyc, 18);
      check("to_rdata", rd, 32'hDEAD_BEEF);
      check("to_err", arb_err, 1);
      repeat (5) @(negedge clk);
      check("to_err_sticky", arb_err, 1);
`else
      check("to_no_ack", cyc, -1);
      check("to_no_err", arb_err, 0);
`endif
      ack_dly = 0;
      do_reset();
      check("final_err_clr", arb_err, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single 1R/1W main memory between the CPU instruction-fetch port and the load/store data port.
- Accepts one request at a time and sequences it onto the memory request interface (req_valid/WE/addr/data).
- Waits for the memory's completion acknowledge, then returns read data and a one-cycle ack to the winning requester.
- Sits between the cpu_top fetch/LSU stages and the memory model.

Parameters:
- ADDR_WIDTH, 32, address width of all address ports.
- DATA_WIDTH, 32, data width of all data ports.
- TIMEOUT_CYCLES, 16, WAIT-state cycle limit; used only when MEM_ARB_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held high until if_ack.
- if_addr  in  ADDR_WIDTH  fetch word address; stable while if_req is high.
- if_ack  out  1  one-cycle pulse; fetch transaction complete.
- if_rdata  out  DATA_WIDTH  fetch data; valid in the if_ack cycle.
- dm_req  in  1  data request; held high until dm_ack.
- dm_we  in  1  1 = write, 0 = read; stable while dm_req is high.
- dm_addr  in  ADDR_WIDTH  data address.
- dm_wdata  in  DATA_WIDTH  write data.
- dm_ack  out  1  one-cycle pulse; data transaction complete.
- dm_rdata  out  DATA_WIDTH  load data; valid in the dm_ack cycle.
- mem_req_valid  out  1  request strobe to memory; one-cycle pulse.
- mem_we  out  1  write enable to memory.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  write data to memory.
- mem_rdata  in  DATA_WIDTH  read data from memory.
- mem_ack  in  1  memory completion pulse.
- arb_err  out  1  sticky error flag (see Optional Feature).

Behaviour:
- Reset values: all outputs 0, FSM = IDLE, last_grant = DM (so fetch wins the first contention).
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - No requests: stay in IDLE.
  - Single request: grant it.
  - Both requests: grant the port opposite to last_grant (round-robin).
  - On grant: latch owner, address, we and wdata (if_* forces we = 0), update last_grant, go to ISSUE.
- ISSUE: drive mem_req_valid = 1 with the latched addr/we/wdata for exactly one cycle, then go to WAIT.
- WAIT:
  - mem_addr/mem_we/mem_wdata hold the latched values; mem_req_valid = 0.
  - On mem_ack: capture mem_rdata (reads only) and go to RESP.
  - mem_ack in any state other than WAIT is ignored.
- RESP:
  - Pulse the owner's ack for one cycle with the registered rdata, then go to IDLE.
  - The non-owner ack stays 0.
  - The rdata output of each port holds its last value until that port's next ack.
- Latency: an uncontended request sees its ack no earlier than 3 cycles after req is sampled (IDLE→ISSUE→WAIT→RESP), plus memory latency.
- Requesters:
  - May deassert req only after seeing ack.
  - A req still high in the cycle after ack is treated as a new request.
- Port changes after grant: changes to the granted port's addr/wdata are ignored; the latched copy is used.
- Write transactions: dm_ack is still pulsed; dm_rdata is unchanged.
- Reset mid-transaction: abandon immediately, drop to IDLE, outputs to 0; memory state is not undone.
- No pipelining: at most one outstanding memory transaction.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit counter increments every WAIT cycle and is cleared on entering WAIT.
  - When it reaches TIMEOUT_CYCLES without mem_ack, go to RESP and ack the owner with rdata = 32'hDEAD_BEEF.
  - arb_err is set and stays high until reset.
- Not defined:
  - WAIT waits indefinitely for mem_ack.
  - arb_err is tied to 0 and no counter is synthesized.

Test Plan:
- Reset: all outputs 0, state IDLE. Then if_req=1, if_addr=0, memory returns 32'h00a00313 one cycle after mem_req_valid → if_ack pulses once with if_rdata=32'h00a00313, and exactly one mem_req_valid pulse is seen.
- DM write then read:
  - Write: dm_we=1, dm_addr=7, dm_wdata=32'h1234_5678 → mem_we=1, dm_ack pulses.
  - Read: dm_we=0, dm_addr=7 → dm_rdata=32'h1234_5678.
- Contention:
  - First cycle out of reset: if_req and dm_req both high → fetch is served first, then data; the acks are at least 4 cycles apart.
  - Repeated contention: grants alternate IF/DM/IF/DM.
- Port changes after grant: dm_addr changes from 3 to 5 during WAIT → mem_addr stays 3 throughout the transaction.
- Reset mid-operation: assert reset in WAIT → no ack is produced, all outputs go to 0; after release a new if_req completes normally.
- Timeout, with MEM_ARB_TIMEOUT_EN defined: mem_ack never arrives → owner ack after TIMEOUT_CYCLES WAIT cycles, rdata=32'hDEAD_BEEF, arb_err=1 and sticky.
- Timeout, without MEM_ARB_TIMEOUT_EN: no ack is produced and arb_err stays 0.
